// File: rtl/id_ex_register.sv
// Decode-to-Execute pipeline register: captures the decoded control bundle and
// operands at the end of Decode, with hazard-unit stall (hold) and flush (bubble).
module id_ex_register #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic                  valid_d,
  input  logic                  reg_write_d,
  input  logic [1:0]            result_src_d,
  input  logic                  mem_write_d,
  input  logic                  jump_d,
  input  logic                  branch_d,
  input  logic                  alu_src_d,
  input  logic [2:0]            alu_control_d,
  input  logic [XLEN-1:0]       rd1_d,
  input  logic [XLEN-1:0]       rd2_d,
  input  logic [XLEN-1:0]       imm_ext_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [XLEN-1:0]       pc_plus4_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  output logic                  valid_e,
  output logic                  reg_write_e,
  output logic [1:0]            result_src_e,
  output logic                  mem_write_e,
  output logic                  jump_e,
  output logic                  branch_e,
  output logic                  alu_src_e,
  output logic [2:0]            alu_control_e,
  output logic [XLEN-1:0]       rd1_e,
  output logic [XLEN-1:0]       rd2_e,
  output logic [XLEN-1:0]       imm_ext_e,
  output logic [XLEN-1:0]       pc_e,
  output logic [XLEN-1:0]       pc_plus4_e,
  output logic [REG_ADDR_W-1:0] rs1_e,
  output logic [REG_ADDR_W-1:0] rs2_e,
  output logic [REG_ADDR_W-1:0] rd_e
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    logic [2:0]            alu_control;
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       imm_ext;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_plus4;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } id_ex_t;

  id_ex_t next_q;
  id_ex_t q;

  // A non-valid slot still travels down the pipe, but can never write state.
  always_comb begin
    // NOTE: default the whole struct first so no field can ever infer a latch.
    next_q             = '0;
    next_q.valid       = valid_d;
    next_q.reg_write   = reg_write_d & valid_d;
    next_q.result_src  = result_src_d;
    next_q.mem_write   = mem_write_d & valid_d;
    next_q.jump        = jump_d;
    next_q.branch      = branch_d;
    next_q.alu_src     = alu_src_d;
    next_q.alu_control = alu_control_d;
    next_q.rd1         = rd1_d;
    next_q.rd2         = rd2_d;
    next_q.imm_ext     = imm_ext_d;
    next_q.pc          = pc_d;
    next_q.pc_plus4    = pc_plus4_d;
    next_q.rs1         = rs1_d;
    next_q.rs2         = rs2_d;
    next_q.rd          = rd_d;
  end

  // Flush outranks stall: a bubble (rd = x0, no writes) is all zeros.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset)         q <= '0;
    else if (flush_e)  q <= '0;
    else if (!stall_e) q <= next_q;
  end

  assign valid_e       = q.valid;
  assign reg_write_e   = q.reg_write;
  assign result_src_e  = q.result_src;
  assign mem_write_e   = q.mem_write;
  assign jump_e        = q.jump;
  assign branch_e      = q.branch;
  assign alu_src_e     = q.alu_src;
  assign alu_control_e = q.alu_control;
  assign rd1_e         = q.rd1;
  assign rd2_e         = q.rd2;
  assign imm_ext_e     = q.imm_ext;
  assign pc_e          = q.pc;
  assign pc_plus4_e    = q.pc_plus4;
  assign rs1_e         = q.rs1;
  assign rs2_e         = q.rs2;
  assign rd_e          = q.rd;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed-vector bench for id_ex_register: reset, load, stall, flush priority,
// invalid-slot write masking and a load-use bubble sequence.
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_e, flush_e;
  logic        valid_d, reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]  result_src_d;
  logic [2:0]  alu_control_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  int n_vec = 0;
  int n_err = 0;

  id_ex_register #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .reg_write_d(reg_write_d), .result_src_d(result_src_d),
    .mem_write_d(mem_write_d), .jump_d(jump_d), .branch_d(branch_d),
    .alu_src_d(alu_src_d), .alu_control_d(alu_control_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .valid_e(valid_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
    .alu_src_e(alu_src_e), .alu_control_e(alu_control_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_d = 0; reg_write_d = 0; mem_write_d = 0; jump_d = 0; branch_d = 0;
    alu_src_d = 0; result_src_d = 0; alu_control_d = 0;
    rd1_d = 0; rd2_d = 0; imm_ext_d = 0; pc_d = 0; pc_plus4_d = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0;
  endtask

  task automatic set_all_nonzero();
    valid_d = 1; reg_write_d = 1; mem_write_d = 1; jump_d = 1; branch_d = 1;
    alu_src_d = 1; result_src_d = 2'b10; alu_control_d = 3'b101;
    rd1_d = 32'hDEAD_BEEF; rd2_d = 32'h1234_5678; imm_ext_d = 32'hFFFF_FFF0;
    pc_d = 32'h0000_0100; pc_plus4_d = 32'h0000_0104;
    rs1_d = 5'd31; rs2_d = 5'd17; rd_d = 5'd9;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},     {31'b0, valid_e},     0);
    check({tag, ".reg_write"}, {31'b0, reg_write_e}, 0);
    check({tag, ".mem_write"}, {31'b0, mem_write_e}, 0);
    check({tag, ".jump"},      {31'b0, jump_e},      0);
    check({tag, ".branch"},    {31'b0, branch_e},    0);
    check({tag, ".alu_src"},   {31'b0, alu_src_e},   0);
    check({tag, ".res_src"},   {30'b0, result_src_e}, 0);
    check({tag, ".alu_ctl"},   {29'b0, alu_control_e}, 0);
    check({tag, ".rd1"},       rd1_e,      0);
    check({tag, ".rd2"},       rd2_e,      0);
    check({tag, ".imm"},       imm_ext_e,  0);
    check({tag, ".pc"},        pc_e,       0);
    check({tag, ".pc4"},       pc_plus4_e, 0);
    check({tag, ".rs1"},       {27'b0, rs1_e}, 0);
    check({tag, ".rs2"},       {27'b0, rs2_e}, 0);
    check({tag, ".rd"},        {27'b0, rd_e},  0);
  endtask

  initial begin
    reset = 1; stall_e = 0; flush_e = 0;
    clear_inputs();
    tick(); tick();
    check_all_zero("por");
    reset = 0;

    // Load a sub; outputs must not follow input changes until the next edge.
    valid_d = 1; reg_write_d = 1; alu_control_d = 3'b001;
    rd1_d = 32'h5; rd2_d = 32'h3; rd_d = 5'd7;
    tick();
    check("sub.alu_ctl",   {29'b0, alu_control_e}, 32'h1);
    check("sub.rd1",       rd1_e, 32'h5);
    check("sub.rd2",       rd2_e, 32'h3);
    check("sub.rd",        {27'b0, rd_e}, 32'd7);
    check("sub.reg_write", {31'b0, reg_write_e}, 1);
    check("sub.valid",     {31'b0, valid_e}, 1);
    rd1_d = 32'h9; rd_d = 5'd12;
    #2;
    check("nocomb.rd1", rd1_e, 32'h5);
    check("nocomb.rd",  {27'b0, rd_e}, 32'd7);
    tick();
    check("upd.rd1", rd1_e, 32'h9);
    check("upd.rd",  {27'b0, rd_e}, 32'd12);

    // Stall holds an slt for three edges while Decode presents an or.
    alu_control_d = 3'b101; pc_d = 32'h10;
    tick();
    check("stl.load.pc",  pc_e, 32'h10);
    check("stl.load.alu", {29'b0, alu_control_e}, 32'h5);
    stall_e = 1; pc_d = 32'h14; alu_control_d = 3'b011;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stl.hold%0d.pc", i),  pc_e, 32'h10);
      check($sformatf("stl.hold%0d.alu", i), {29'b0, alu_control_e}, 32'h5);
    end
    stall_e = 0;
    tick();
    check("stl.rel.pc",  pc_e, 32'h14);
    check("stl.rel.alu", {29'b0, alu_control_e}, 32'h3);

    // Flush wins over stall; a valid sw is replaced by a bubble.
    set_all_nonzero();
    tick();
    check("sw.mem_write", {31'b0, mem_write_e}, 1);
    check("sw.pc",        pc_e, 32'h100);
    check("sw.rs1",       {27'b0, rs1_e}, 32'd31);
    stall_e = 1; flush_e = 1;
    tick();
    check_all_zero("fl_stl");
    stall_e = 0;
    tick();
    check_all_zero("fl_b2b");
    flush_e = 0; stall_e = 1;
    tick();
    check_all_zero("fl_hold");
    stall_e = 0;

    // A non-valid slot is captured verbatim except its write enables.
    clear_inputs();
    reg_write_d = 1; mem_write_d = 1; alu_control_d = 3'b010; pc_d = 32'h20;
    tick();
    check("inv.reg_write", {31'b0, reg_write_e}, 0);
    check("inv.mem_write", {31'b0, mem_write_e}, 0);
    check("inv.alu_ctl",   {29'b0, alu_control_e}, 32'h2);
    check("inv.valid",     {31'b0, valid_e}, 0);
    check("inv.pc",        pc_e, 32'h20);

    // Load-use: lw x5,8(x2) then add x6,x5,x1 behind a one-cycle bubble.
    clear_inputs();
    valid_d = 1; reg_write_d = 1; result_src_d = 2'b01; alu_src_d = 1;
    rs1_d = 5'd2; rd_d = 5'd5; imm_ext_d = 32'h8;
    tick();
    check("lw.rd",      {27'b0, rd_e}, 32'd5);
    check("lw.res_src", {30'b0, result_src_e}, 32'd1);
    check("lw.imm",     imm_ext_e, 32'h8);
    result_src_d = 2'b00; alu_src_d = 0; alu_control_d = 3'b000;
    rs1_d = 5'd5; rs2_d = 5'd1; rd_d = 5'd6; imm_ext_d = 0;
    flush_e = 1;
    tick();
    check_all_zero("lu_bub");
    flush_e = 0;
    tick();
    check("add.rs1",       {27'b0, rs1_e}, 32'd5);
    check("add.rs2",       {27'b0, rs2_e}, 32'd1);
    check("add.rd",        {27'b0, rd_e}, 32'd6);
    check("add.alu_ctl",   {29'b0, alu_control_e}, 32'h0);
    check("add.valid",     {31'b0, valid_e}, 1);
    check("add.reg_write", {31'b0, reg_write_e}, 1);

    // Asynchronous reset mid-stall clears outputs before any clock edge.
    set_all_nonzero();
    tick();
    check("pre_rst.rd1", rd1_e, 32'hDEAD_BEEF);
    check("pre_rst.jump", {31'b0, jump_e}, 1);
    stall_e = 1;
    #2 reset = 1;
    #1;
    check_all_zero("arst");
    tick();
    check_all_zero("arst_held");
    #4 reset = 0; stall_e = 0;
    tick();
    check("post_rst.rd1",    rd1_e, 32'hDEAD_BEEF);
    check("post_rst.pc4",    pc_plus4_e, 32'h104);
    check("post_rst.branch", {31'b0, branch_e}, 1);
    check("post_rst.rd2",    rd2_e, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
